// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the instruction port, data port and shared Avalon master signals.
// The arbiter connects through the master modport; the environment drives through slave.
interface mem_bus_arbiter_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    // instruction port
    logic [ADDR_W-1:0] i_address;
    logic              i_read;
    logic              i_waitrequest;
    logic [DATA_W-1:0] i_readdata;
    // data port
    logic [ADDR_W-1:0] d_address;
    logic              d_read;
    logic              d_write;
    logic [DATA_W-1:0] d_writedata;
    logic [BE_W-1:0]   d_byteenable;
    logic              d_waitrequest;
    logic [DATA_W-1:0] d_readdata;
    // shared bus
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              grant_d;

    modport master (
        input  i_address, i_read, d_address, d_read, d_write, d_writedata, d_byteenable,
        input  waitrequest, readdata,
        output i_waitrequest, i_readdata, d_waitrequest, d_readdata,
        output address, read, write, writedata, byteenable, grant_d
    );

    modport slave (
        output i_address, i_read, d_address, d_read, d_write, d_writedata, d_byteenable,
        output waitrequest, readdata,
        input  i_waitrequest, i_readdata, d_waitrequest, d_readdata,
        input  address, read, write, writedata, byteenable, grant_d
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port (instruction/data) arbiter onto one Avalon master with same-cycle grant,
// lock-until-complete on stalled transfers and optional round-robin on contention.
module mem_bus_arbiter #(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    mem_bus_arbiter_if.master   bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOCK_I = 2'd1;
    localparam logic [1:0] LOCK_D = 2'd2;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    logic [1:0] state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       i_req, d_req;
    logic       gnt_i, gnt_d;

    // Grant decision: combinational in IDLE, held while locked, none during reset.
    always_comb begin
        i_req = bus.i_read;
        d_req = bus.d_read | bus.d_write;
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (d_req && (!i_req || !RR_ENABLE || (last_grant_q == GNT_I))) begin
                        gnt_d = 1'b1;
                    end else if (i_req) begin
                        gnt_i = 1'b1;
                    end
                end
                LOCK_I:  gnt_i = 1'b1;
                LOCK_D:  gnt_d = 1'b1;
                default: ;
            endcase
        end
    end

    // Next state: lock on a stalled grant, release on bus completion.
    // Completion while locked is judged on waitrequest alone so a dropped request cannot hang the bus.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (gnt_d) begin
                    if (bus.waitrequest) state_d = LOCK_D;
                    else                 last_grant_d = GNT_D;
                end else if (gnt_i) begin
                    if (bus.waitrequest) state_d = LOCK_I;
                    else                 last_grant_d = GNT_I;
                end
            end
            LOCK_I: begin
                if (!bus.waitrequest) begin
                    state_d      = IDLE;
                    last_grant_d = GNT_I;
                end
            end
            LOCK_D: begin
                if (!bus.waitrequest) begin
                    state_d      = IDLE;
                    last_grant_d = GNT_D;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_I;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Bus mux and per-port response routing.
    always_comb begin
        bus.address       = 32'h0;
        bus.read          = 1'b0;
        bus.write         = 1'b0;
        bus.writedata     = 32'h0;
        bus.byteenable    = 4'h0;
        bus.i_readdata    = 32'h0;
        bus.d_readdata    = 32'h0;
        bus.i_waitrequest = gnt_i ? bus.waitrequest : i_req;
        bus.d_waitrequest = gnt_d ? bus.waitrequest : d_req;
        bus.grant_d       = gnt_d;
        if (gnt_d) begin
            bus.address    = bus.d_address;
            bus.write      = bus.d_write;
            bus.read       = bus.d_read & ~bus.d_write;
            bus.writedata  = bus.d_writedata;
            bus.byteenable = bus.d_byteenable;
            bus.d_readdata = bus.readdata;
        end else if (gnt_i) begin
            // Instruction fetches are always full-word reads.
            bus.address    = bus.i_address;
            bus.read       = bus.i_read;
            bus.byteenable = 4'hF;
            bus.i_readdata = bus.readdata;
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one round-robin instance and one fixed-priority instance.
module tb_mem_bus_arbiter;
    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    mem_bus_arbiter_if bus_rr ();
    mem_bus_arbiter_if bus_fp ();

    mem_bus_arbiter #(.RR_ENABLE(1'b1)) u_rr (.clk(clk), .reset(reset), .bus(bus_rr));
    mem_bus_arbiter #(.RR_ENABLE(1'b0)) u_fp (.clk(clk), .reset(reset), .bus(bus_fp));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_rr.i_address = 32'h0; bus_rr.i_read = 1'b0;
        bus_rr.d_address = 32'h0; bus_rr.d_read = 1'b0; bus_rr.d_write = 1'b0;
        bus_rr.d_writedata = 32'h0; bus_rr.d_byteenable = 4'h0;
        bus_rr.waitrequest = 1'b0; bus_rr.readdata = 32'h0;
        bus_fp.i_address = 32'h0; bus_fp.i_read = 1'b0;
        bus_fp.d_address = 32'h0; bus_fp.d_read = 1'b0; bus_fp.d_write = 1'b0;
        bus_fp.d_writedata = 32'h0; bus_fp.d_byteenable = 4'h0;
        bus_fp.waitrequest = 1'b0; bus_fp.readdata = 32'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        bus_rr.i_read = 1'b1; bus_rr.i_address = 32'h1234_0000;
        bus_rr.d_write = 1'b1; bus_rr.d_writedata = 32'hFFFF_FFFF; bus_rr.d_byteenable = 4'hF;
        bus_fp.d_read = 1'b1;
        tick();
        tick();
        tests_run++;
        if (bus_rr.read !== 1'b0 || bus_rr.write !== 1'b0) begin
            tests_failed++; $display("FAIL reset_rw: read=%0b write=%0b want 0 0", bus_rr.read, bus_rr.write); end
        tests_run++;
        if (bus_rr.address !== 32'h0 || bus_rr.writedata !== 32'h0 || bus_rr.byteenable !== 4'h0) begin
            tests_failed++; $display("FAIL reset_bus: addr=%h wd=%h be=%h want 0", bus_rr.address, bus_rr.writedata, bus_rr.byteenable); end
        tests_run++;
        if (bus_rr.i_waitrequest !== 1'b1 || bus_rr.d_waitrequest !== 1'b1 || bus_rr.grant_d !== 1'b0) begin
            tests_failed++; $display("FAIL reset_wait_rr: iw=%0b dw=%0b gd=%0b want 1 1 0", bus_rr.i_waitrequest, bus_rr.d_waitrequest, bus_rr.grant_d); end
        tests_run++;
        if (bus_fp.i_waitrequest !== 1'b0 || bus_fp.d_waitrequest !== 1'b1 || bus_fp.read !== 1'b0) begin
            tests_failed++; $display("FAIL reset_wait_fp: iw=%0b dw=%0b rd=%0b want 0 1 0", bus_fp.i_waitrequest, bus_fp.d_waitrequest, bus_fp.read); end
        reset = 1'b0;
        clear_inputs();
    endtask

    task automatic test_i_read();
        do_reset();
        bus_rr.i_read = 1'b1; bus_rr.i_address = 32'hBFC0_0000;
        bus_rr.waitrequest = 1'b0; bus_rr.readdata = 32'h1234_5678;
        #1;
        tests_run++;
        if (bus_rr.read !== 1'b1 || bus_rr.address !== 32'hBFC0_0000 || bus_rr.byteenable !== 4'hF) begin
            tests_failed++; $display("FAIL iread_bus: rd=%0b addr=%h be=%h want 1 bfc00000 f", bus_rr.read, bus_rr.address, bus_rr.byteenable); end
        tests_run++;
        if (bus_rr.i_readdata !== 32'h1234_5678 || bus_rr.d_readdata !== 32'h0) begin
            tests_failed++; $display("FAIL iread_data: ird=%h drd=%h want 12345678 0", bus_rr.i_readdata, bus_rr.d_readdata); end
        tests_run++;
        if (bus_rr.i_waitrequest !== 1'b0 || bus_rr.d_waitrequest !== 1'b0 || bus_rr.grant_d !== 1'b0) begin
            tests_failed++; $display("FAIL iread_wait: iw=%0b dw=%0b gd=%0b want 0 0 0", bus_rr.i_waitrequest, bus_rr.d_waitrequest, bus_rr.grant_d); end
        tick();
        bus_rr.readdata = 32'h0BAD_CAFE;
        #1;
        tests_run++;
        if (bus_rr.read !== 1'b1 || bus_rr.i_readdata !== 32'h0BAD_CAFE || bus_rr.i_waitrequest !== 1'b0) begin
            tests_failed++; $display("FAIL iread_stay_idle: rd=%0b ird=%h iw=%0b want 1 0badcafe 0", bus_rr.read, bus_rr.i_readdata, bus_rr.i_waitrequest); end
        clear_inputs();
    endtask

    task automatic test_contention();
        do_reset();
        bus_rr.i_read = 1'b1; bus_rr.i_address = 32'h0000_0040;
        bus_rr.d_read = 1'b1; bus_rr.d_address = 32'h0000_0100;
        bus_rr.waitrequest = 1'b0; bus_rr.readdata = 32'hAAAA_5555;
        #1;
        tests_run++;
        if (bus_rr.grant_d !== 1'b1 || bus_rr.address !== 32'h0000_0100 || bus_rr.d_readdata !== 32'hAAAA_5555) begin
            tests_failed++; $display("FAIL cont_first_d: gd=%0b addr=%h drd=%h want 1 100 aaaa5555", bus_rr.grant_d, bus_rr.address, bus_rr.d_readdata); end
        tests_run++;
        if (bus_rr.i_waitrequest !== 1'b1 || bus_rr.d_waitrequest !== 1'b0 || bus_rr.i_readdata !== 32'h0) begin
            tests_failed++; $display("FAIL cont_first_stall: iw=%0b dw=%0b ird=%h want 1 0 0", bus_rr.i_waitrequest, bus_rr.d_waitrequest, bus_rr.i_readdata); end
        tick();
        tests_run++;
        if (bus_rr.grant_d !== 1'b0 || bus_rr.address !== 32'h0000_0040 || bus_rr.i_waitrequest !== 1'b0 || bus_rr.d_waitrequest !== 1'b1) begin
            tests_failed++; $display("FAIL cont_second_i: gd=%0b addr=%h iw=%0b dw=%0b want 0 40 0 1", bus_rr.grant_d, bus_rr.address, bus_rr.i_waitrequest, bus_rr.d_waitrequest); end
        tick();
        tests_run++;
        if (bus_rr.grant_d !== 1'b1 || bus_rr.address !== 32'h0000_0100) begin
            tests_failed++; $display("FAIL cont_third_d: gd=%0b addr=%h want 1 100", bus_rr.grant_d, bus_rr.address); end
        clear_inputs();
        tick();
    endtask

    task automatic test_lock_d();
        clear_inputs();
        tick();
        bus_rr.d_write = 1'b1; bus_rr.d_address = 32'h0000_0200;
        bus_rr.d_writedata = 32'hDEAD_BEEF; bus_rr.d_byteenable = 4'hF;
        bus_rr.waitrequest = 1'b1;
        #1;
        tests_run++;
        if (bus_rr.grant_d !== 1'b1 || bus_rr.write !== 1'b1 || bus_rr.read !== 1'b0 || bus_rr.d_waitrequest !== 1'b1) begin
            tests_failed++; $display("FAIL lockd_start: gd=%0b wr=%0b rd=%0b dw=%0b want 1 1 0 1", bus_rr.grant_d, bus_rr.write, bus_rr.read, bus_rr.d_waitrequest); end
        tick();
        bus_rr.i_read = 1'b1; bus_rr.i_address = 32'h0000_0080;
        for (int c = 1; c <= 2; c++) begin
            #1;
            tests_run++;
            if (bus_rr.grant_d !== 1'b1 || bus_rr.write !== 1'b1 || bus_rr.writedata !== 32'hDEAD_BEEF ||
                bus_rr.byteenable !== 4'hF || bus_rr.address !== 32'h0000_0200 || bus_rr.i_waitrequest !== 1'b1) begin
                tests_failed++;
                $display("FAIL lockd_hold%0d: gd=%0b wr=%0b wd=%h be=%h addr=%h iw=%0b want 1 1 deadbeef f 200 1",
                         c, bus_rr.grant_d, bus_rr.write, bus_rr.writedata, bus_rr.byteenable, bus_rr.address, bus_rr.i_waitrequest);
            end
            tick();
        end
        bus_rr.waitrequest = 1'b0;
        #1;
        tests_run++;
        if (bus_rr.grant_d !== 1'b1 || bus_rr.write !== 1'b1 || bus_rr.d_waitrequest !== 1'b0 || bus_rr.i_waitrequest !== 1'b1) begin
            tests_failed++; $display("FAIL lockd_complete: gd=%0b wr=%0b dw=%0b iw=%0b want 1 1 0 1", bus_rr.grant_d, bus_rr.write, bus_rr.d_waitrequest, bus_rr.i_waitrequest); end
        tick();
        tests_run++;
        if (bus_rr.grant_d !== 1'b0 || bus_rr.read !== 1'b1 || bus_rr.write !== 1'b0 || bus_rr.address !== 32'h0000_0080 ||
            bus_rr.i_waitrequest !== 1'b0 || bus_rr.d_waitrequest !== 1'b1) begin
            tests_failed++; $display("FAIL lockd_then_i: gd=%0b rd=%0b wr=%0b addr=%h iw=%0b dw=%0b want 0 1 0 80 0 1",
                                     bus_rr.grant_d, bus_rr.read, bus_rr.write, bus_rr.address, bus_rr.i_waitrequest, bus_rr.d_waitrequest); end
        clear_inputs();
        tick();
    endtask

    task automatic test_lock_i_reset();
        clear_inputs();
        tick();
        bus_rr.d_read = 1'b1; bus_rr.d_address = 32'h0000_0300;
        #1;
        tests_run++;
        if (bus_rr.grant_d !== 1'b1) begin
            tests_failed++; $display("FAIL locki_pre_d: gd=%0b want 1", bus_rr.grant_d); end
        tick();
        bus_rr.d_read = 1'b0;
        bus_rr.i_read = 1'b1; bus_rr.i_address = 32'h0000_0080; bus_rr.waitrequest = 1'b1;
        #1;
        tests_run++;
        if (bus_rr.grant_d !== 1'b0 || bus_rr.read !== 1'b1 || bus_rr.i_waitrequest !== 1'b1) begin
            tests_failed++; $display("FAIL locki_start: gd=%0b rd=%0b iw=%0b want 0 1 1", bus_rr.grant_d, bus_rr.read, bus_rr.i_waitrequest); end
        tick();
        bus_rr.d_read = 1'b1;
        #1;
        tests_run++;
        if (bus_rr.grant_d !== 1'b0 || bus_rr.address !== 32'h0000_0080 || bus_rr.d_waitrequest !== 1'b1 || bus_rr.i_waitrequest !== 1'b1) begin
            tests_failed++; $display("FAIL locki_hold: gd=%0b addr=%h dw=%0b iw=%0b want 0 80 1 1", bus_rr.grant_d, bus_rr.address, bus_rr.d_waitrequest, bus_rr.i_waitrequest); end
        reset = 1'b1;
        #1;
        tests_run++;
        if (bus_rr.read !== 1'b0 || bus_rr.address !== 32'h0 || bus_rr.i_waitrequest !== 1'b1 || bus_rr.d_waitrequest !== 1'b1) begin
            tests_failed++; $display("FAIL locki_in_reset: rd=%0b addr=%h iw=%0b dw=%0b want 0 0 1 1", bus_rr.read, bus_rr.address, bus_rr.i_waitrequest, bus_rr.d_waitrequest); end
        tick();
        reset = 1'b0;
        bus_rr.waitrequest = 1'b0;
        #1;
        tests_run++;
        if (bus_rr.grant_d !== 1'b1 || bus_rr.read !== 1'b1 || bus_rr.address !== 32'h0000_0300) begin
            tests_failed++; $display("FAIL locki_after_reset: gd=%0b rd=%0b addr=%h want 1 1 300", bus_rr.grant_d, bus_rr.read, bus_rr.address); end
        clear_inputs();
        tick();
    endtask

    task automatic test_rw_both();
        clear_inputs();
        tick();
        bus_rr.d_read = 1'b1; bus_rr.d_write = 1'b1; bus_rr.d_address = 32'h0000_0500;
        bus_rr.d_writedata = 32'h0102_0304; bus_rr.d_byteenable = 4'h3;
        #1;
        tests_run++;
        if (bus_rr.write !== 1'b1 || bus_rr.read !== 1'b0 || bus_rr.writedata !== 32'h0102_0304 || bus_rr.byteenable !== 4'h3) begin
            tests_failed++; $display("FAIL rw_both: wr=%0b rd=%0b wd=%h be=%h want 1 0 01020304 3", bus_rr.write, bus_rr.read, bus_rr.writedata, bus_rr.byteenable); end
        clear_inputs();
        tick();
    endtask

    task automatic test_fixed_priority();
        clear_inputs();
        tick();
        bus_fp.i_read = 1'b1; bus_fp.i_address = 32'h0000_0010;
        bus_fp.d_read = 1'b1; bus_fp.d_address = 32'h0000_0020;
        bus_fp.waitrequest = 1'b0;
        for (int t = 0; t < 4; t++) begin
            #1;
            tests_run++;
            if (bus_fp.grant_d !== 1'b1 || bus_fp.address !== 32'h0000_0020 || bus_fp.i_waitrequest !== 1'b1) begin
                tests_failed++; $display("FAIL fixed_xfer%0d: gd=%0b addr=%h iw=%0b want 1 20 1", t, bus_fp.grant_d, bus_fp.address, bus_fp.i_waitrequest); end
            tick();
        end
        bus_fp.d_read = 1'b0;
        #1;
        tests_run++;
        if (bus_fp.grant_d !== 1'b0 || bus_fp.address !== 32'h0000_0010 || bus_fp.i_waitrequest !== 1'b0) begin
            tests_failed++; $display("FAIL fixed_i_alone: gd=%0b addr=%h iw=%0b want 0 10 0", bus_fp.grant_d, bus_fp.address, bus_fp.i_waitrequest); end
        clear_inputs();
        tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        clear_inputs();
        test_reset();
        test_i_read();
        test_contention();
        test_lock_d();
        test_lock_i_reset();
        test_rw_both();
        test_fixed_priority();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter: RR_ENABLE, 1, 1 = round-robin between ports on contention, 0 = fixed priority to data port.
REQ-002 SHALL have: clk  input  1  rising-edge clock.
REQ-003 SHALL have: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have: i_address  input  32  instruction-port word address.
REQ-005 SHALL have: i_read  input  1  instruction-port read request.
REQ-006 SHALL have: i_waitrequest  output  1  instruction-port stall.
REQ-007 SHALL have: i_readdata  output  32  instruction-port read data.
REQ-008 SHALL have: d_address  input  32  data-port address.
REQ-009 SHALL have: d_read, d_write  input  1 each  data-port requests.
REQ-010 SHALL have: d_writedata  input  32; d_byteenable  input  4.
REQ-011 SHALL have: d_waitrequest  output  1; d_readdata  output  32.
REQ-012 SHALL have: address  output  32; read, write  output  1; writedata  output  32; byteenable  output  4  (shared Avalon master).
REQ-013 SHALL have: waitrequest  input  1; readdata  input  32  (shared Avalon slave response).
REQ-014 SHALL have: grant_d  output  1  data port currently owns the bus (debug/observation).

Function
REQ-015 SHALL implement FSM states IDLE, LOCK_I, LOCK_D; reset and decided clock as stated: reset reset, synchronous, active-high; clock clk.
REQ-016 In IDLE, SHALL grant combinationally in the same cycle: only one port requesting -> that port; both requesting -> per REQ-017.
REQ-017 Contention: RR_ENABLE=1 -> grant the port not granted last (last_grant register, reset value = I, so D wins first contention); RR_ENABLE=0 -> D always.
REQ-018 Granted port's address/read/write/writedata/byteenable SHALL drive the bus unchanged; with no grant, read=write=0, address=0, writedata=0, byteenable=0.
REQ-019 A transfer SHALL complete on the cycle granted read or write is high and waitrequest=0; readdata SHALL route to the granted port's *_readdata in that cycle (zero-latency read).
REQ-020 If granted in IDLE and waitrequest=1, FSM SHALL move to LOCK_x next cycle and hold that grant until completion, regardless of the other port's requests.
REQ-021 In LOCK_x, on completion FSM SHALL return to IDLE; next arbitration happens in the following cycle (no back-to-back re-grant in the completing cycle).
REQ-022 Granted port's *_waitrequest SHALL equal bus waitrequest; a requesting non-granted port SHALL see *_waitrequest=1; a non-requesting port SHALL see 0.
REQ-023 last_grant SHALL update on every completed transfer to the completing port.
REQ-024 d_read and d_write both high is illegal; arbiter SHALL forward write only and suppress read.
REQ-025 A requester dropping its request while locked is illegal; arbiter SHALL keep grant until bus completion or reset.
REQ-026 Non-granted *_readdata SHALL read 0.
REQ-027 grant_d SHALL be 1 exactly when the data port is granted (IDLE combinational or LOCK_D).

Reset
REQ-028 While reset=1: state <= IDLE, last_grant <= I, all bus outputs 0, both *_waitrequest 1 if requesting else 0.
REQ-029 Reset asserted mid-transfer SHALL abandon the grant next edge; no completion reported to either port.
REQ-030 First cycle after reset deassertion SHALL arbitrate normally from IDLE.

Verification
REQ-031 I-only read, address 0xBFC00000, waitrequest=0 -> read=1, address=0xBFC00000 same cycle; i_readdata = readdata; FSM stays IDLE.
REQ-032 Both request, RR_ENABLE=1, after reset -> D granted first, I stalled (i_waitrequest=1); next arbitration grants I.
REQ-033 D write 0xDEADBEEF byteenable 0xF, waitrequest high 3 cycles -> LOCK_D held 3 cycles, write/data stable, I stalled throughout, completes on 4th cycle.
REQ-034 RR_ENABLE=0, both requesting continuously for 4 transfers -> D granted every transfer, I never granted.
REQ-035 Reset pulse during LOCK_I -> next cycle IDLE, read=0, last_grant=I.
REQ-036 d_read=d_write=1 -> write=1, read=0 on bus.
